// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared return-state/owner encodings and sizing helpers for mem_arbiter
package mem_arb_pkg;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  typedef logic [1:0] ret_state_t;
  localparam ret_state_t S_IDLE  = OWN_NONE;
  localparam ret_state_t S_RD_IF = OWN_IF;
  localparam ret_state_t S_RD_D  = OWN_D;
  localparam int STARVE_MAX_DEF = 4;
  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/mem_be_expand.sv
// mem_be_expand: expands byte enables into a per-bit write mask
//   be_i   : one enable per byte lane
//   mask_o : each byte enable replicated across its 8 bits
module mem_be_expand #(
  parameter int DW = 32
) (
  input  logic [DW/8-1:0] be_i,
  output logic [DW-1:0]   mask_o
);
  for (genvar k = 0; k < DW / 8; k++) begin : g_lane
    assign mask_o[8*k +: 8] = {8{be_i[k]}};
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: IF/D arbiter and sequencer for a single-port SRAM with 1-cycle read latency
//   clk, rst                  : clock, synchronous active-high reset
//   if_req/if_addr/if_gnt     : IF read request, address, combinational grant
//   if_rvalid/if_rdata        : IF read return
//   d_req/d_we/d_addr/d_be/d_wdata/d_gnt : D request (read or byte-masked write) and grant
//   d_rvalid/d_rdata          : D read return
//   mem_cen/mem_wen/mem_bwen/mem_a/mem_d/mem_q : SRAM macro interface
//   MEM_ARB_RDATA_HOLD_EN     : when defined, rdata outputs hold the last returned word
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [AW-1:0]         if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DW-1:0]         if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [AW-1:0]         d_addr,
  input  logic [be_w(DW)-1:0]   d_be,
  input  logic [DW-1:0]         d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DW-1:0]         d_rdata,
  output logic                  mem_cen,
  output logic                  mem_wen,
  output logic [DW-1:0]         mem_bwen,
  output logic [AW-1:0]         mem_a,
  output logic [DW-1:0]         mem_d,
  input  logic [DW-1:0]         mem_q
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0]    cnt_q, cnt_d;
  ret_state_t    state_q, state_d;
  logic [DW-1:0] wmask;
  logic          d_wr;
  mem_be_expand #(.DW(DW)) u_be (.be_i(d_be), .mask_o(wmask));
  assign if_gnt   = !rst && if_req && (!d_req || cnt_q == SMAX);
  assign d_gnt    = !rst && d_req && !if_gnt;
  assign d_wr     = d_gnt && d_we;
  assign mem_cen  = !(if_gnt || d_gnt);
  assign mem_wen  = !d_wr;
  assign mem_bwen = d_wr ? wmask : '0;
  assign mem_d    = d_wr ? d_wdata : '0;
  assign mem_a    = if_gnt ? if_addr : d_gnt ? d_addr : '0;
  assign cnt_d    = (!if_req || if_gnt) ? 4'd0 : (cnt_q == SMAX) ? cnt_q : cnt_q + 4'd1;
  assign state_d  = if_gnt ? S_RD_IF : (d_gnt && !d_we) ? S_RD_D : S_IDLE;
  // a return pending when rst arrives is dropped, not delivered
  assign if_rvalid = !rst && state_q == S_RD_IF;
  assign d_rvalid  = !rst && state_q == S_RD_D;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end
`ifdef MEM_ARB_RDATA_HOLD_EN
  logic [DW-1:0] if_hold_q, d_hold_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      if (if_rvalid) if_hold_q <= mem_q;
      if (d_rvalid) d_hold_q <= mem_q;
    end
  end
  assign if_rdata = if_rvalid ? mem_q : if_hold_q;
  assign d_rdata  = d_rvalid ? mem_q : d_hold_q;
`else
  assign if_rdata = if_rvalid ? mem_q : '0;
  assign d_rdata  = d_rvalid ? mem_q : '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a behavioural SRAM
module tb_mem_arbiter;
  logic        clk = 0;
  logic        rst, if_req, d_req, d_we;
  logic [7:0]  if_addr, d_addr, mem_a;
  logic [3:0]  d_be;
  logic [31:0] d_wdata, if_rdata, d_rdata, mem_bwen, mem_d, mem_q;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_cen, mem_wen;
  logic [31:0] sram [256];
  logic [31:0] q = '0;
  int          checks = 0, errors = 0;
  int          p_own;
  logic [7:0]  p_addr, ia, da;
  logic        e_if;
  logic [31:0] hold_if_exp, hold_d_exp;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_bwen(mem_bwen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!mem_cen) begin
      if (!mem_wen) sram[mem_a] <= (sram[mem_a] & ~mem_bwen) | (mem_d & mem_bwen);
      else q <= sram[mem_a];
    end
  assign mem_q = q;

  function automatic logic [31:0] f(input logic [7:0] a);
    return 32'hA500_0000 | {24'd0, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = f(8'(i));
    sram[8'h10] = 32'h1122_3344;
    sram[8'h55] = 32'hCAFE_F00D;
`ifdef MEM_ARB_RDATA_HOLD_EN
    hold_if_exp = 32'hA500_0001;
    hold_d_exp  = 32'hCAFE_F00D;
`else
    hold_if_exp = 32'h0;
    hold_d_exp  = 32'h0;
`endif
    ia = 8'h40; da = 8'h20; p_own = 0; p_addr = '0;
    rst = 1; if_req = 1; d_req = 1; d_we = 0; if_addr = ia; d_addr = da; d_be = '0; d_wdata = '0;
    repeat (3) begin
      cyc;
      check("rst_if_gnt", if_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_cen", mem_cen, 1);
      check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    end
    rst = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        cyc;
        check("ctn_if_rv", if_rvalid, p_own == 1);
        check("ctn_d_rv", d_rvalid, p_own == 2);
        check("ctn_rdata", p_own == 1 ? if_rdata : d_rdata, f(p_addr));
        if (p_own == 1) ia++; else da++;
        if_addr = ia; d_addr = da;
      end
      #1;
      e_if = (k % 5 == 4);
      check("ctn_if_gnt", if_gnt, e_if);
      check("ctn_d_gnt", d_gnt, !e_if);
      check("ctn_addr", mem_a, e_if ? ia : da);
      p_own = e_if ? 1 : 2;
      p_addr = e_if ? ia : da;
    end
    cyc;
    if_req = 0; d_req = 0;
    check("ctn_last_rv", if_rvalid, 1);
    check("ctn_last_rd", if_rdata, f(ia));
    d_req = 1; d_we = 1; d_addr = 8'h10; d_be = 4'b0101; d_wdata = 32'hAABB_CCDD;
    #1;
    check("wr_gnt", d_gnt, 1);
    check("wr_if_gnt", if_gnt, 0);
    check("wr_cen", mem_cen, 0);
    check("wr_wen", mem_wen, 0);
    check("wr_bwen", mem_bwen, 32'h00FF_00FF);
    check("wr_a", mem_a, 8'h10);
    check("wr_d", mem_d, 32'hAABB_CCDD);
    cyc;
    check("wr_no_rv", d_rvalid, 0);
    d_be = 4'b0000; d_wdata = 32'hFFFF_FFFF;
    #1;
    check("be0_gnt", d_gnt, 1);
    check("be0_bwen", mem_bwen, 0);
    check("be0_wen", mem_wen, 0);
    cyc;
    check("be0_no_rv", d_rvalid, 0);
    d_we = 0;
    #1;
    check("rd_wen", mem_wen, 1);
    check("rd_bwen", mem_bwen, 0);
    check("rd_d", mem_d, 0);
    cyc;
    d_req = 0;
    check("rd_rv", d_rvalid, 1);
    check("rd_data", d_rdata, 32'h11BB_33DD);
    #1;
    check("idle_cen", mem_cen, 1);
    check("idle_a", mem_a, 0);
    check("idle_wen", mem_wen, 1);
    if_req = 1; if_addr = 8'h01;
    #1;
    check("b2b_if_gnt", if_gnt, 1);
    check("b2b_if_a", mem_a, 8'h01);
    cyc;
    if_req = 0; d_req = 1; d_addr = 8'h02;
    check("b2b_if_rv", if_rvalid, 1);
    check("b2b_if_rd", if_rdata, 32'hA500_0001);
    check("b2b_d_rv0", d_rvalid, 0);
    #1;
    check("b2b_d_gnt", d_gnt, 1);
    cyc;
    d_req = 0;
    check("b2b_d_rv", d_rvalid, 1);
    check("b2b_d_rd", d_rdata, 32'hA500_0002);
    check("b2b_if_rv0", if_rvalid, 0);
    check("b2b_if_rd0", if_rdata, hold_if_exp);
    if_req = 1; if_addr = 8'h03;
    #1;
    check("mr_if_gnt", if_gnt, 1);
    cyc;
    rst = 1; if_req = 0;
    #1;
    check("mr_no_rv", if_rvalid, 0);
    check("mr_gnt", if_gnt, 0);
    cyc;
    rst = 0;
    if_req = 1; d_req = 1; if_addr = 8'h05; d_addr = 8'h04;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("sr_pre_d_gnt", d_gnt, 1);
      cyc;
    end
    rst = 1;
    #1;
    check("sr_rst_gnt", {if_gnt, d_gnt}, 0);
    cyc;
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("sr_post_if_gnt", if_gnt, k == 4);
      cyc;
    end
    if_req = 0; d_req = 0;
    cyc;
    d_req = 1; d_addr = 8'h55;
    #1;
    check("hold_gnt", d_gnt, 1);
    cyc;
    d_req = 0;
    check("hold_rv", d_rvalid, 1);
    check("hold_rd", d_rdata, 32'hCAFE_F00D);
    repeat (5) begin
      cyc;
      check("hold_idle_rv", d_rvalid, 0);
      check("hold_idle_rd", d_rdata, hold_d_exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the core's single-port 256x32 SRAM macro.
- Requesters are instruction fetch (IF, read-only) and load/store (D, read/write with byte enables).
- Drives the macro's active-low chip enable and write enable, plus its per-bit write mask.
- Routes the 1-cycle-latency read data back to whichever requester issued the read.
- Sits between the pipeline's IF and MEM stages and the SRAM.

Parameters:
- AW, 8, word address width; memory depth is 2^AW.
- DW, 32, data width; must be a multiple of 8.
- STARVE_MAX, 4, number of consecutive lost IF arbitrations before IF is forced ahead of D; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request; held until granted.
- if_addr  in  AW  IF word address.
- if_gnt  out  1  IF request accepted this cycle (combinational).
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  DW  IF read data.
- d_req  in  1  D request; held until granted.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  D word address.
- d_be  in  DW/8  byte enables for writes.
- d_wdata  in  DW  write data.
- d_gnt  out  1  D request accepted this cycle (combinational).
- d_rvalid  out  1  D read data valid.
- d_rdata  out  DW  D read data.
- mem_cen  out  1  SRAM chip enable, active low.
- mem_wen  out  1  SRAM mode: 1 = read, 0 = write.
- mem_bwen  out  DW  SRAM per-bit write mask, 1 = write that bit.
- mem_a  out  AW  SRAM address.
- mem_d  out  DW  SRAM write data.
- mem_q  in  DW  SRAM read data; valid the cycle after a read access.

Behaviour:
- Grant, combinational, at most one per cycle:
  - IF wins when if_req && (!d_req || starve_cnt == STARVE_MAX).
  - Otherwise D wins when d_req.
- Memory drive when a grant is given: mem_cen = 0; mem_a = winner's address.
  - D write: mem_wen = 0; mem_bwen[8k+7:8k] = {8{d_be[k]}}; mem_d = d_wdata.
  - Any read: mem_wen = 1; mem_bwen = 0.
- Memory drive with no grant: mem_cen = 1, mem_wen = 1, mem_bwen = 0, mem_a = 0, mem_d = 0.
- D write with d_be = 0 is still granted and consumes the cycle; memory contents are unchanged; no rvalid.
- starve_cnt (4-bit):
  - Increments, saturating at STARVE_MAX, on each cycle with if_req && !if_gnt.
  - Clears when if_gnt is asserted or when if_req = 0.
- Return FSM, states S_IDLE, S_RD_IF, S_RD_D; next state depends only on this cycle's grant:
  - IF read granted -> S_RD_IF.
  - D read granted -> S_RD_D.
  - D write granted or no grant -> S_IDLE.
- Return data:
  - In S_RD_IF: if_rvalid = 1 and if_rdata = mem_q.
  - In S_RD_D: d_rvalid = 1 and d_rdata = mem_q.
  - rdata outputs are 0 when the matching rvalid is 0.
- Read latency is 1 cycle from grant to rvalid. Back-to-back grants are allowed, so throughput is one access per cycle.
- Reset (rst = 1), taking effect from the next edge:
  - FSM -> S_IDLE; starve_cnt -> 0.
  - During rst both gnt outputs are forced to 0 and the memory outputs are held at the no-grant values.
  - A read granted in the cycle before rst is asserted gets no rvalid; its pending return is dropped.
- Simultaneous D write and IF read under starvation: IF wins and D waits. No write is ever lost; D holds the request until granted.
- Address wrap needs no handling: AW bits map directly onto the full depth.

Optional Feature:
- Macro: MEM_ARB_RDATA_HOLD_EN.
- Defined:
  - if_rdata and d_rdata come from per-port registers loaded from mem_q in the rvalid cycle.
  - Each port's data stays stable until that port's next rvalid; rvalid timing is unchanged.
  - In the rvalid cycle the output equals mem_q (bypass).
  - The hold registers reset to 0.
- Undefined: rdata is 0 outside rvalid, as specified above.

Decomposition:
- Package mem_arb_pkg:
  - Return-state enum (S_IDLE / S_RD_IF / S_RD_D).
  - Owner encoding constants.
  - BE_W = DW/8 helper.
  - Default STARVE_MAX.
- Sub-module mem_be_expand: combinational byte-enable to bit-mask expansion, parameterised on DW.
- Arbitration, counter and FSM stay in the top module.

Test Plan:
- Reset: hold rst 3 cycles with both reqs high -> gnts 0, mem_cen = 1, rvalids 0. After release, cycle 1 gives d_gnt = 1.
- D write then read: write addr 0x10, d_be = 4'b0101, d_wdata = 0xAABBCCDD over a preloaded 0x11223344 -> mem_bwen = 0x00FF00FF. A D read of 0x10 gives d_rvalid one cycle later with d_rdata = 0x11BB33DD.
- Contention: IF and D both request continuously (D reads) with STARVE_MAX = 4 -> grant pattern D,D,D,D,IF repeating. if_rvalid/d_rvalid each follow their grant by exactly 1 cycle with correct data.
- Back-to-back routing: grant IF read of 0x01, then D read of 0x02 -> if_rvalid is followed by d_rvalid in consecutive cycles, each carrying its own word, with no cross-routing.
- Reset mid-read: IF read granted at cycle N, rst asserted at cycle N+1 -> if_rvalid stays 0; starve_cnt reads 0 after reset.
- With MEM_ARB_RDATA_HOLD_EN: D read returns 0xCAFEF00D, then 5 idle cycles -> d_rdata stays 0xCAFEF00D and d_rvalid stays 0.
